// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 sequential controller: instruction codes,
// architectural status codes and the controller state encoding.
// Optional feature macro: Y86_SINGLE_STEP_EN (adds the PAUSE state).
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_HALTED,
        S_FAULT
`ifdef Y86_SINGLE_STEP_EN
        ,S_PAUSE
`endif
    } state_t;

    // Instructions that touch data memory and therefore pass through MEMORY.
    function automatic logic is_mem_icode(input logic [3:0] ic);
        return (ic == I_RMMOVQ) || (ic == I_MRMOVQ) || (ic == I_CALL) ||
               (ic == I_RET)    || (ic == I_PUSHQ)  || (ic == I_POPQ);
    endfunction

endpackage

// File: rtl/y86_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module y86_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Count while inc is high, holding once every bit is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/y86_seq_controller.sv
// Multi-cycle stage sequencer for the sequential Y86-64 core. Walks the
// stages one per cycle, resolves fetch/memory status into stat, and keeps
// cycle and retired-instruction counters.
// Optional feature macro: Y86_SINGLE_STEP_EN (step input, PAUSE after PC update).
//
// state     | meaning
// IDLE      | waiting for start
// FETCH     | fetch stage active; fetch status decides fault/halt/continue
// DECODE    | decode stage active
// EXECUTE   | execute stage active; cc written for OPq
// MEMORY    | memory stage active for 1+MEM_WAIT cycles
// WRITEBACK | register file write
// PCUPD     | PC load; instruction retires
// PAUSE     | (single-step build) waiting for step
// HALTED    | stopped by HALT, stat=HLT
// FAULT     | stopped by address/instruction error, stat=ADR/INS
module y86_seq_controller
    import y86_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MEM_WAIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef Y86_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             dmem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             cc_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic [2:0]       stat,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_retired
);

    localparam logic [3:0] LP_MEM_WAIT = 4'(MEM_WAIT);

    state_t     r_state, w_next;
    logic [2:0] r_stat, w_stat_next;
    logic [3:0] r_wait, w_wait_next;
    logic       w_run;
    logic       w_retire;

    // State, status and memory-wait registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_stat  <= STAT_AOK;
            r_wait  <= 4'd0;
        end else begin
            r_state <= w_next;
            r_stat  <= w_stat_next;
            r_wait  <= w_wait_next;
        end
    end

    // Next-state, status and wait-counter logic.
    always_comb begin
        w_next      = r_state;
        w_stat_next = r_stat;
        w_wait_next = r_wait;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_error) begin
                    w_next      = S_FAULT;
                    w_stat_next = STAT_ADR;
                end else if (!instr_valid) begin
                    w_next      = S_FAULT;
                    w_stat_next = STAT_INS;
                end else if (icode == I_HALT) begin
                    w_next      = S_HALTED;
                    w_stat_next = STAT_HLT;
                end else begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: w_next = S_EXECUTE;
            S_EXECUTE: begin
                if (is_mem_icode(icode)) begin
                    w_next      = S_MEMORY;
                    w_wait_next = LP_MEM_WAIT;
                end else begin
                    w_next = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                // dmem_error only matters on the final memory cycle.
                if (r_wait != 4'd0) begin
                    w_wait_next = r_wait - 4'd1;
                end else if (dmem_error) begin
                    w_next      = S_FAULT;
                    w_stat_next = STAT_ADR;
                end else begin
                    w_next = S_WRITEBACK;
                end
            end
            S_WRITEBACK: w_next = S_PCUPD;
`ifdef Y86_SINGLE_STEP_EN
            S_PCUPD: w_next = S_PAUSE;
            S_PAUSE: begin
                if (step) w_next = S_FETCH;
            end
`else
            S_PCUPD: w_next = S_FETCH;
`endif
            S_HALTED: w_next = S_HALTED;
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_IDLE;
        endcase
    end

    // Moore output decode from the state register.
    always_comb begin
        fetch_en  = (r_state == S_FETCH);
        decode_en = (r_state == S_DECODE);
        exec_en   = (r_state == S_EXECUTE);
        cc_en     = (r_state == S_EXECUTE) && (icode == I_OPQ);
        mem_en    = (r_state == S_MEMORY);
        wb_en     = (r_state == S_WRITEBACK);
        pc_en     = (r_state == S_PCUPD);
        done      = (r_state == S_HALTED) || (r_state == S_FAULT);
        w_run     = fetch_en || decode_en || exec_en || mem_en || wb_en || pc_en;
        w_retire  = pc_en;
    end

    assign stat = r_stat;

    y86_sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_run),
        .count (cycle_count)
    );

    y86_sat_counter #(.WIDTH(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_retire),
        .count (instr_retired)
    );

endmodule

// File: tb/tb_y86_seq_controller.sv
// Self-checking bench for y86_seq_controller: directed scenarios plus random
// instruction streams compared against a per-instruction stage-list model.
module tb_y86_seq_controller;

    localparam int MW = 2;
    localparam logic [6:0] EN_F  = 7'b1000000;
    localparam logic [6:0] EN_D  = 7'b0100000;
    localparam logic [6:0] EN_E  = 7'b0010000;
    localparam logic [6:0] EN_CC = 7'b0001000;
    localparam logic [6:0] EN_M  = 7'b0000100;
    localparam logic [6:0] EN_W  = 7'b0000010;
    localparam logic [6:0] EN_P  = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        step = 1'b1;
    logic [3:0]  icode = 4'd0;
    logic        instr_valid = 1'b0;
    logic        imem_error = 1'b0;
    logic        dmem_error = 1'b0;
    logic        fetch_en, decode_en, exec_en, cc_en, mem_en, wb_en, pc_en;
    logic [2:0]  stat;
    logic        done;
    logic [31:0] cycle_count, instr_retired;
    logic [6:0]  w_en;

    logic        sat_inc = 1'b0;
    logic [2:0]  sat_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cycles = 0;
    int exp_retired = 0;

    always #5 clk = ~clk;

    assign w_en = {fetch_en, decode_en, exec_en, cc_en, mem_en, wb_en, pc_en};

    y86_seq_controller #(.CNT_W(32), .MEM_WAIT(MW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
`ifdef Y86_SINGLE_STEP_EN
        .step          (step),
`endif
        .icode         (icode),
        .instr_valid   (instr_valid),
        .imem_error    (imem_error),
        .dmem_error    (dmem_error),
        .fetch_en      (fetch_en),
        .decode_en     (decode_en),
        .exec_en       (exec_en),
        .cc_en         (cc_en),
        .mem_en        (mem_en),
        .wb_en         (wb_en),
        .pc_en         (pc_en),
        .stat          (stat),
        .done          (done),
        .cycle_count   (cycle_count),
        .instr_retired (instr_retired)
    );

    y86_sat_counter #(.WIDTH(3)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sat_inc),
        .count (sat_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_en", w_en, 0);
        chk("rst_stat", stat, 1);
        chk("rst_done", done, 0);
        chk("rst_cyc", cycle_count, 0);
        chk("rst_ret", instr_retired, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_en", w_en, 0);
        chk("idle_cyc", cycle_count, 0);
        exp_cycles  = 0;
        exp_retired = 0;
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Model: list the enable pattern each cycle of one instruction should show,
    // then drive the instruction and compare cycle by cycle.
    task automatic run_instr(input logic [3:0] ic, input bit valid, input bit ierr,
                             input bit derr, output bit term);
        logic [6:0] q[$];
        int         mem_last;
        logic [2:0] tstat;
        mem_last = -1;
        tstat    = 3'd1;
        term     = 1'b0;
        q.push_back(EN_F);
        if (ierr) begin
            term = 1'b1; tstat = 3'd3;
        end else if (!valid) begin
            term = 1'b1; tstat = 3'd4;
        end else if (ic == 4'd0) begin
            term = 1'b1; tstat = 3'd2;
        end else begin
            q.push_back(EN_D);
            q.push_back((ic == 4'd6) ? (EN_E | EN_CC) : EN_E);
            if (ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
                for (int k = 0; k <= MW; k++) q.push_back(EN_M);
                mem_last = q.size() - 1;
            end
            if (mem_last >= 0 && derr) begin
                term = 1'b1; tstat = 3'd3;
            end else begin
                q.push_back(EN_W);
                q.push_back(EN_P);
`ifdef Y86_SINGLE_STEP_EN
                q.push_back(7'b0);
`endif
            end
        end
        for (int i = 0; i < q.size(); i++) begin
            icode       = ic;
            instr_valid = (i == 0) ? valid : 1'($urandom);
            imem_error  = (i == 0) ? ierr  : 1'($urandom);
            dmem_error  = (i == mem_last) ? derr : 1'($urandom);
            #1;
            chk("en", w_en, q[i]);
            chk("stat_run", stat, 1);
            chk("cyc", cycle_count, exp_cycles);
            if (q[i] != 7'b0) exp_cycles++;
            if (q[i] == EN_P) exp_retired++;
            @(negedge clk);
        end
        if (term) begin
            #1;
            chk("term_done", done, 1);
            chk("term_stat", stat, tstat);
            chk("term_en", w_en, 0);
            chk("term_cyc", cycle_count, exp_cycles);
            chk("term_ret", instr_retired, exp_retired);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            #1;
            chk("term_hold", {done, w_en, stat}, {1'b1, 7'b0, tstat});
            chk("term_cyc_hold", cycle_count, exp_cycles);
        end
    endtask

    initial begin
        bit t;
        // Three NOPs then HALT.
        do_reset();
        start_run();
        repeat (3) run_instr(4'h1, 1'b1, 1'b0, 1'b0, t);
        run_instr(4'h0, 1'b1, 1'b0, 1'b0, t);
        chk("tp1_cyc", cycle_count, 16);
        chk("tp1_ret", instr_retired, 3);

        // MRMOVQ with two memory wait cycles, then HALT.
        do_reset();
        start_run();
        run_instr(4'h5, 1'b1, 1'b0, 1'b0, t);
        chk("tp2_ret", instr_retired, 1);
        run_instr(4'h0, 1'b1, 1'b0, 1'b0, t);

        // Address error wins over invalid instruction.
        do_reset();
        start_run();
        run_instr(4'h1, 1'b1, 1'b0, 1'b0, t);
        run_instr(4'h3, 1'b0, 1'b1, 1'b0, t);
        chk("tp3_ret", instr_retired, 1);

        // PUSHQ with data error on final memory cycle.
        do_reset();
        start_run();
        run_instr(4'hA, 1'b1, 1'b0, 1'b1, t);
        chk("tp4_ret", instr_retired, 0);

        // OPq raises cc_en in EXECUTE; CMOVXX does not.
        do_reset();
        start_run();
        run_instr(4'h6, 1'b1, 1'b0, 1'b0, t);
        run_instr(4'h2, 1'b1, 1'b0, 1'b0, t);
        run_instr(4'h0, 1'b1, 1'b0, 1'b0, t);

        // Asynchronous reset in the middle of MEMORY.
        do_reset();
        start_run();
        icode = 4'h5; instr_valid = 1'b1; imem_error = 1'b0; dmem_error = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("ar_mem", w_en, EN_M);
        chk("ar_cyc_pre", cycle_count, 3);
        rst_n = 1'b0;
        #1;
        chk("ar_en", w_en, 0);
        chk("ar_cyc", cycle_count, 0);
        chk("ar_stat_done", {stat, done}, {3'd1, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("ar_idle", w_en, 0);

        // Random instruction streams.
        for (int p = 0; p < 15; p++) begin
            do_reset();
            start_run();
            t = 1'b0;
            for (int j = 0; j < 10 && !t; j++) begin
                run_instr(4'($urandom_range(1, 11)), $urandom_range(0, 9) != 0,
                          $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, t);
            end
            if (!t) run_instr(4'h0, 1'b1, 1'b0, 1'b0, t);
        end

        // Saturating counter sticks at all-ones.
        do_reset();
        sat_inc = 1'b1;
        repeat (10) @(negedge clk);
        sat_inc = 1'b0;
        #1;
        chk("sat", sat_count, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
